y_position_counter: RTL and testbench

Y_POSITION_COUNTER -- requirements
Module: y_position_counter

---
 rtl/y_position_counter.sv | 96 +++++++++
 tb/tb_y_position_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/y_position_counter.sv
// Vertical position register for a stacked block: moves by STEP per detected request edge within [Y_MIN, Y_INIT].
// Optional stacked-level counter enabled by defining Y_LEVEL_COUNT_EN.
module y_position_counter #(
  parameter int Y_WIDTH   = 7,
  parameter int Y_INIT    = 104,
  parameter int STEP      = 16,
  parameter int Y_MIN     = 8,
  parameter int LVL_WIDTH = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               dec,
  input  logic               inc,
  output logic [Y_WIDTH-1:0] curr_y_position,
  output logic               top_reached,
  output logic               step_done,
  output logic               rejected
`ifdef Y_LEVEL_COUNT_EN
  ,
  output logic [LVL_WIDTH-1:0] level
`endif
);

  localparam int XW = Y_WIDTH + 1;
  // Limits are held one bit wider than the position so y+STEP cannot wrap.
  localparam logic [XW-1:0] UP_LIMIT  = XW'(Y_MIN + STEP);
  localparam logic [XW-1:0] STEP_X    = XW'(STEP);
  localparam logic [XW-1:0] INIT_X    = XW'(Y_INIT);
  localparam logic          RESET_TOP = (INIT_X < UP_LIMIT);

  logic               dec_d;
  logic               inc_d;
  logic               dec_edge;
  logic               inc_edge;
  logic [XW-1:0]      y_x;
  logic [Y_WIDTH-1:0] y_next;
  logic               top_next;
  logic               step_next;
  logic               rej_next;

  always_comb begin
    dec_edge  = dec & ~dec_d;
    inc_edge  = inc & ~inc_d;
    y_x       = {1'b0, curr_y_position};
    y_next    = curr_y_position;
    step_next = 1'b0;
    rej_next  = 1'b0;
    if (enable && dec_edge && !inc_edge) begin
      if (y_x >= UP_LIMIT) begin
        y_next    = curr_y_position - Y_WIDTH'(STEP);
        step_next = 1'b1;
      end else begin
        rej_next = 1'b1;
      end
    end else if (enable && inc_edge && !dec_edge) begin
      if (y_x + STEP_X <= INIT_X) begin
        y_next    = curr_y_position + Y_WIDTH'(STEP);
        step_next = 1'b1;
      end else begin
        rej_next = 1'b1;
      end
    end
    top_next = ({1'b0, y_next} < UP_LIMIT);
  end

  always_ff @(posedge clk) begin
    // Edge history follows the inputs even in reset so held requests do not fire on release.
    dec_d <= dec;
    inc_d <= inc;
    if (!resetn) begin
      curr_y_position <= Y_WIDTH'(Y_INIT);
      top_reached     <= RESET_TOP;
      step_done       <= 1'b0;
      rejected        <= 1'b0;
    end else begin
      curr_y_position <= y_next;
      top_reached     <= top_next;
      step_done       <= step_next;
      rejected        <= rej_next;
    end
  end

`ifdef Y_LEVEL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level <= '0;
    end else if (step_next && dec_edge) begin
      if (level != '1) level <= level + 1'b1;
    end else if (step_next && inc_edge) begin
      if (level != '0) level <= level - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_y_position_counter.sv
// Directed bench for y_position_counter: integer reference model checked every cycle plus literal checkpoints.
module tb_y_position_counter;

  localparam int Y_WIDTH = 7, Y_INIT = 104, STEP = 16, Y_MIN = 8, LVL_WIDTH = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  logic dec = 1'b0;
  logic inc = 1'b0;
  logic [Y_WIDTH-1:0] curr_y_position;
  logic top_reached, step_done, rejected;
`ifdef Y_LEVEL_COUNT_EN
  logic [LVL_WIDTH-1:0] level;
`endif

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  y_position_counter #(
    .Y_WIDTH(Y_WIDTH), .Y_INIT(Y_INIT), .STEP(STEP), .Y_MIN(Y_MIN), .LVL_WIDTH(LVL_WIDTH)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .dec(dec), .inc(inc),
    .curr_y_position(curr_y_position), .top_reached(top_reached),
    .step_done(step_done), .rejected(rejected)
`ifdef Y_LEVEL_COUNT_EN
    , .level(level)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer position within [Y_MIN, Y_INIT].
  int  m_y = Y_INIT, m_lvl = 0;
  bit  m_sd = 0, m_rej = 0, m_valid = 0;
  bit  m_pdec = 0, m_pinc = 0;
  always @(posedge clk) begin
    bit de, ie;
    de = dec && !m_pdec;
    ie = inc && !m_pinc;
    m_pdec = dec;
    m_pinc = inc;
    m_sd = 0;
    m_rej = 0;
    if (!resetn) begin
      m_y = Y_INIT;
      m_lvl = 0;
      m_valid = 1;
    end else if (enable && de && !ie) begin
      if (m_y - STEP >= Y_MIN) begin
        m_y -= STEP; m_sd = 1;
        if (m_lvl < (1 << LVL_WIDTH) - 1) m_lvl++;
      end else m_rej = 1;
    end else if (enable && ie && !de) begin
      if (m_y + STEP <= Y_INIT) begin
        m_y += STEP; m_sd = 1;
        if (m_lvl > 0) m_lvl--;
      end else m_rej = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("model_y", int'(curr_y_position), m_y);
      check("model_top", int'(top_reached), int'(m_y < Y_MIN + STEP));
      check("model_step_done", int'(step_done), int'(m_sd));
      check("model_rejected", int'(rejected), int'(m_rej));
`ifdef Y_LEVEL_COUNT_EN
      check("model_level", int'(level), m_lvl);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_dec();
    dec = 1'b1; cyc(1); dec = 1'b0;
  endtask

  task automatic pulse_inc();
    inc = 1'b1; cyc(1); inc = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; cyc(2); resetn = 1'b1;
  endtask

  int up_tab[6] = '{88, 72, 56, 40, 24, 8};

  initial begin
    cyc(3);
    check("reset_y", int'(curr_y_position), 104);
    check("reset_top", int'(top_reached), 0);
    check("reset_step", int'(step_done), 0);
    check("reset_rej", int'(rejected), 0);
    resetn = 1'b1;
    cyc(1);

    pulse_dec();
    check("dec1_y", int'(curr_y_position), 88);
    check("dec1_step", int'(step_done), 1);
`ifdef Y_LEVEL_COUNT_EN
    check("dec1_level", int'(level), 1);
`endif
    cyc(1);
    check("dec1_step_clear", int'(step_done), 0);

    pulse_inc();
    check("inc88_y", int'(curr_y_position), 104);
    check("inc88_step", int'(step_done), 1);
    cyc(1);
    pulse_inc();
    check("inc104_y", int'(curr_y_position), 104);
    check("inc104_rej", int'(rejected), 1);
    cyc(1);

    for (int i = 0; i < 6; i++) begin
      pulse_dec();
      check("climb_y", int'(curr_y_position), up_tab[i]);
      cyc(1);
    end
    check("climb_top", int'(top_reached), 1);
    pulse_dec();
    check("over_y", int'(curr_y_position), 8);
    check("over_rej", int'(rejected), 1);
`ifdef Y_LEVEL_COUNT_EN
    check("over_level", int'(level), 6);
`endif
    cyc(1);

    for (int i = 0; i < 5; i++) begin
      pulse_inc();
      cyc(1);
    end
    check("descend_y", int'(curr_y_position), 88);
    check("descend_top", int'(top_reached), 0);
    dec = 1'b1; inc = 1'b1; cyc(1); dec = 1'b0; inc = 1'b0;
    check("cancel_y", int'(curr_y_position), 88);
    check("cancel_step", int'(step_done), 0);
    check("cancel_rej", int'(rejected), 0);
    cyc(1);

    resetn = 1'b0; dec = 1'b1; cyc(1); dec = 1'b0; resetn = 1'b1;
    check("reset_prio_y", int'(curr_y_position), 104);
    cyc(1);

    dec = 1'b1; cyc(10); dec = 1'b0; cyc(1);
    check("held_dec_y", int'(curr_y_position), 88);

    dec = 1'b1; resetn = 1'b0; cyc(2); resetn = 1'b1; cyc(3); dec = 1'b0; cyc(1);
    check("held_reset_y", int'(curr_y_position), 104);

    enable = 1'b0; pulse_dec(); cyc(1);
    check("disabled_y", int'(curr_y_position), 104);
    dec = 1'b1; cyc(2); enable = 1'b1; cyc(2); dec = 1'b0; cyc(1);
    check("enable_rise_y", int'(curr_y_position), 104);
    check("enable_rise_step", int'(step_done), 0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
